uart_pix_packer: RTL and testbench

Byte-to-pixel assembler that sits directly upstream of the frame RAM writer in the photo-frame datapath. It takes 8-bit bytes from the UART receiver, hunts for a frame header, and unpacks RGB444 pixels (3 bytes per 2 pixels). It presents each pixel as a one-cycle rx_valid/rx_data strobe, which the RAM stage consumes while state equals RX_STATE. It also flags frame completion and framing or timeout errors.

---
 rtl/uart_pix_packer.sv | 136 +++++++++++++
 tb/tb_uart_pix_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pix_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_pix_packer
// Purpose  : Hunts for a two-byte frame header in the UART byte stream and
//            unpacks RGB444 pixels (3 bytes -> 2 pixels) for the frame RAM.
// Revision : 1.0
// ============================================================================
module uart_pix_packer #(
   parameter int         W        = 3,
   parameter int         H        = 2,
   parameter logic [7:0] RX_STATE = 8'h02,
   parameter logic [7:0] HDR0     = 8'hA5,
   parameter logic [7:0] HDR1     = 8'h5A,
   parameter int         TIMEOUT  = 50000
) (
   input  logic        i_clk_sys,
   input  logic        i_rst_n,
   input  logic [7:0]  state,
   input  logic        i_byte_vld,
   input  logic [7:0]  i_byte,
   output logic        rx_valid,
   output logic [11:0] rx_data,
   output logic [14:0] pix_cnt,
   output logic        frame_done,
   output logic        rx_err,
   output logic        busy
);

   localparam int          c_TW     = $clog2(TIMEOUT + 1);
   localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT - 1);
   localparam logic [14:0] c_LAST   = 15'(W * H - 1);

   typedef enum logic [2:0] {
      HUNT0 = 3'd0,
      HUNT1 = 3'd1,
      B0    = 3'd2,
      B1    = 3'd3,
      B2    = 3'd4
   } fsm_t;

   fsm_t             r_fsm,   w_fsm_nxt;
   logic [7:0]       r_hi,    w_hi_nxt;
   logic [3:0]       r_lo_hi, w_lo_nxt;
   logic [c_TW-1:0]  r_idle,  w_idle_nxt;
   logic             w_valid_nxt, w_done_nxt, w_err_nxt;
   logic [11:0]      w_data_nxt;
   logic [14:0]      w_cnt_nxt;
   logic             w_accept, w_last, w_in_payload;

   assign w_accept     = i_byte_vld && (state == RX_STATE);
   assign w_last       = (pix_cnt == c_LAST);
   assign w_in_payload = (r_fsm == B0) || (r_fsm == B1) || (r_fsm == B2);
   assign busy         = (r_fsm != HUNT0);

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo_hi;
      w_idle_nxt  = '0;
      w_valid_nxt = 1'b0;
      w_data_nxt  = rx_data;
      w_cnt_nxt   = pix_cnt;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;

      if (state != RX_STATE) begin
         w_fsm_nxt = HUNT0;
      end else if (w_accept) begin
         case (r_fsm)
            HUNT0: if (i_byte == HDR0) w_fsm_nxt = HUNT1;
            HUNT1: begin
               if (i_byte == HDR1) begin
                  w_fsm_nxt = B0;
                  w_cnt_nxt = '0;
               end else if (i_byte != HDR0) begin
                  w_fsm_nxt = HUNT0;
               end
            end
            B0: begin
               w_hi_nxt  = i_byte;
               w_fsm_nxt = B1;
            end
            B1: begin
               w_valid_nxt = 1'b1;
               w_data_nxt  = {r_hi, i_byte[7:4]};
               w_lo_nxt    = i_byte[3:0];
               w_cnt_nxt   = pix_cnt + 15'd1;
               w_done_nxt  = w_last;
               w_fsm_nxt   = w_last ? HUNT0 : B2;
            end
            B2: begin
               w_valid_nxt = 1'b1;
               w_data_nxt  = {r_lo_hi, i_byte};
               w_cnt_nxt   = pix_cnt + 15'd1;
               w_done_nxt  = w_last;
               w_fsm_nxt   = w_last ? HUNT0 : B0;
            end
            default: w_fsm_nxt = HUNT0;
         endcase
      end else if (w_in_payload) begin
         // Silence inside a frame: abort once the inter-byte gap is exhausted
         if (r_idle == c_TO_MAX) begin
            w_err_nxt = 1'b1;
            w_fsm_nxt = HUNT0;
         end else begin
            w_idle_nxt = r_idle + c_TW'(1);
         end
      end
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm      <= HUNT0;
         r_hi       <= '0;
         r_lo_hi    <= '0;
         r_idle     <= '0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         pix_cnt    <= '0;
         frame_done <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         r_fsm      <= w_fsm_nxt;
         r_hi       <= w_hi_nxt;
         r_lo_hi    <= w_lo_nxt;
         r_idle     <= w_idle_nxt;
         rx_valid   <= w_valid_nxt;
         rx_data    <= w_data_nxt;
         pix_cnt    <= w_cnt_nxt;
         frame_done <= w_done_nxt;
         rx_err     <= w_err_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_pix_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_pix_packer
// Purpose  : Scoreboard bench for uart_pix_packer (3x2 and odd 3x1 frames).
// Revision : 1.0
// ============================================================================
module tb_uart_pix_packer;

   localparam int TO = 50000;

   typedef struct packed {
      logic [11:0] d;
      logic [14:0] c;
      logic        f;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  st;
   logic        vld_a, vld_b;
   logic [7:0]  byte_in;

   logic        rx_valid_a, frame_done_a, rx_err_a, busy_a;
   logic [11:0] rx_data_a;
   logic [14:0] pix_cnt_a;
   logic        rx_valid_b, frame_done_b, rx_err_b, busy_b;
   logic [11:0] rx_data_b;
   logic [14:0] pix_cnt_b;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [7:0]  tx[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          err_a = 0;
   int          err_b = 0;

   always #5 clk = ~clk;

   uart_pix_packer #(.W(3), .H(2), .TIMEOUT(TO)) dut_a (
      .i_clk_sys(clk), .i_rst_n(rst_n), .state(st),
      .i_byte_vld(vld_a), .i_byte(byte_in),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .pix_cnt(pix_cnt_a),
      .frame_done(frame_done_a), .rx_err(rx_err_a), .busy(busy_a)
   );

   uart_pix_packer #(.W(3), .H(1), .TIMEOUT(TO)) dut_b (
      .i_clk_sys(clk), .i_rst_n(rst_n), .state(st),
      .i_byte_vld(vld_b), .i_byte(byte_in),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .pix_cnt(pix_cnt_b),
      .frame_done(frame_done_b), .rx_err(rx_err_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_a(input logic [11:0] d, input int c, input logic f);
      q_a.push_back('{d: d, c: 15'(c), f: f});
   endtask

   task automatic push_b(input logic [11:0] d, input int c, input logic f);
      q_b.push_back('{d: d, c: 15'(c), f: f});
   endtask

   task automatic send(input bit to_b, input logic [7:0] b);
      @(negedge clk);
      byte_in = b;
      if (to_b) vld_b = 1'b1;
      else      vld_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic send_all(input bit to_b);
      foreach (tx[i]) send(to_b, tx[i]);
   endtask

   task automatic push_frame1();
      push_a(12'h123, 1, 1'b0); push_a(12'h456, 2, 1'b0);
      push_a(12'h789, 3, 1'b0); push_a(12'hABC, 4, 1'b0);
      push_a(12'hDEF, 5, 1'b0); push_a(12'h011, 6, 1'b1);
      tx = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11};
   endtask

   // Monitor: pops the expected pixel whenever a DUT strobes one
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rx_valid_a) begin
            if (q_a.size() == 0) begin
               n_total++;
               $display("FAIL pixel_a: unexpected pixel %h cnt %0d", rx_data_a, pix_cnt_a);
            end else begin
               e = q_a.pop_front();
               chk("pixel_a data", 32'(rx_data_a), 32'(e.d));
               chk("pixel_a cnt", 32'(pix_cnt_a), 32'(e.c));
               chk("pixel_a done", 32'(frame_done_a), 32'(e.f));
            end
         end else if (frame_done_a) begin
            n_total++;
            $display("FAIL done_a: frame_done %0d without rx_valid (required 0)", frame_done_a);
         end
         if (rx_valid_b) begin
            if (q_b.size() == 0) begin
               n_total++;
               $display("FAIL pixel_b: unexpected pixel %h cnt %0d", rx_data_b, pix_cnt_b);
            end else begin
               e = q_b.pop_front();
               chk("pixel_b data", 32'(rx_data_b), 32'(e.d));
               chk("pixel_b cnt", 32'(pix_cnt_b), 32'(e.c));
               chk("pixel_b done", 32'(frame_done_b), 32'(e.f));
            end
         end else if (frame_done_b) begin
            n_total++;
            $display("FAIL done_b: frame_done %0d without rx_valid (required 0)", frame_done_b);
         end
         if (rx_err_a) err_a++;
         if (rx_err_b) err_b++;
      end
   end

   initial begin
      int first_err;
      rst_n   = 1'b0;
      st      = 8'h02;
      vld_a   = 1'b0;
      vld_b   = 1'b0;
      byte_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset rx_valid", 32'(rx_valid_a), 0);
      chk("reset rx_data", 32'(rx_data_a), 0);
      chk("reset pix_cnt", 32'(pix_cnt_a), 0);
      chk("reset frame_done", 32'(frame_done_a), 0);
      chk("reset rx_err", 32'(rx_err_a), 0);
      chk("reset busy", 32'(busy_a), 0);
      rst_n = 1'b1;

      // Full 3x2 frame
      push_frame1();
      send_all(1'b0);
      repeat (3) @(negedge clk);
      chk("frame1 pix_cnt", 32'(pix_cnt_a), 6);
      chk("frame1 busy", 32'(busy_a), 0);
      chk("frame1 drained", 32'(q_a.size()), 0);

      // Odd pixel count: last low nibble is padding
      push_b(12'hABC, 1, 1'b0); push_b(12'hDEF, 2, 1'b0); push_b(12'h123, 3, 1'b1);
      tx = '{8'hA5, 8'h5A, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h3F};
      send_all(1'b1);
      repeat (3) @(negedge clk);
      chk("odd pix_cnt", 32'(pix_cnt_b), 3);
      chk("odd busy", 32'(busy_b), 0);
      chk("odd drained", 32'(q_b.size()), 0);

      // Header resync, then state leaves RX_STATE mid-frame
      push_a(12'h112, 1, 1'b0); push_a(12'h233, 2, 1'b0);
      tx = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
      send_all(1'b0);
      chk("resync busy mid-frame", 32'(busy_a), 1);
      st = 8'h03;
      repeat (2) @(negedge clk);
      chk("state change busy", 32'(busy_a), 0);
      tx = '{8'h55, 8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56};
      send_all(1'b0);
      chk("off-state busy", 32'(busy_a), 0);
      chk("off-state pix_cnt hold", 32'(pix_cnt_a), 2);
      st = 8'h02;
      chk("resync drained", 32'(q_a.size()), 0);

      // Header bytes inside payload are data
      push_a(12'hA55, 1, 1'b0); push_a(12'hAA5, 2, 1'b0);
      push_a(12'h5AA, 3, 1'b0); push_a(12'h55A, 4, 1'b0);
      push_a(12'hA55, 5, 1'b0); push_a(12'hAA5, 6, 1'b1);
      tx = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
      send_all(1'b0);
      repeat (2) @(negedge clk);
      chk("hdr-data pix_cnt", 32'(pix_cnt_a), 6);

      // Timeout after a partial pixel
      push_a(12'h123, 1, 1'b0);
      tx = '{8'hA5, 8'h5A, 8'h12, 8'h34};
      send_all(1'b0);
      first_err = -1;
      for (int i = 1; i <= TO + 20; i++) begin
         @(negedge clk);
         if (rx_err_a && first_err < 0) first_err = i;
      end
      chk("timeout latency", 32'(first_err), 32'(TO));
      chk("timeout pulse count", 32'(err_a), 1);
      chk("timeout busy", 32'(busy_a), 0);
      chk("timeout pix_cnt hold", 32'(pix_cnt_a), 1);
      push_frame1();
      send_all(1'b0);
      repeat (3) @(negedge clk);
      chk("post-timeout pix_cnt", 32'(pix_cnt_a), 6);

      // Asynchronous reset while in B1
      tx = '{8'hA5, 8'h5A, 8'h12};
      send_all(1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst rx_data", 32'(rx_data_a), 0);
      chk("async rst pix_cnt", 32'(pix_cnt_a), 0);
      chk("async rst busy", 32'(busy_a), 0);
      chk("async rst rx_valid", 32'(rx_valid_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      push_frame1();
      send_all(1'b0);
      repeat (4) @(negedge clk);
      chk("final pix_cnt", 32'(pix_cnt_a), 6);
      chk("final drained a", 32'(q_a.size()), 0);
      chk("final drained b", 32'(q_b.size()), 0);
      chk("no stray rx_err a", 32'(err_a), 1);
      chk("no stray rx_err b", 32'(err_b), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
